// File: rtl/mem_writer_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_writer_arbiter_pkg
// Shared types and constants for the MemWriter two-client arbiter.
//   state_e           : arbiter FSM states (IDLE, REQ, DATA, RESP)
//   ADDR_W_DEF/DATA_W_DEF : default widths of offset/length and data fields
//   req_width/data_in_width : derived channel widths
//   REQ_LEN_LSB, DIN_LAST_BIT, req_offset_lsb, din_len_lsb, din_data_lsb :
//                       field positions inside the req and data_in words
//   resp_e            : MemWriter response status codes
// -----------------------------------------------------------------------------
package mem_writer_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } state_e;

    typedef enum logic {
        RESP_OKAY  = 1'b0,
        RESP_ERROR = 1'b1
    } resp_e;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 32;

    // req word is {offset, length}; data_in word is {data, length, last}
    localparam int REQ_LEN_LSB  = 0;
    localparam int DIN_LAST_BIT = 0;

    function automatic int req_width(input int addr_w);
        return 2 * addr_w;
    endfunction

    function automatic int data_in_width(input int addr_w, input int data_w);
        return data_w + addr_w + 1;
    endfunction

    function automatic int req_offset_lsb(input int addr_w);
        return addr_w;
    endfunction

    function automatic int din_len_lsb();
        return 1;
    endfunction

    function automatic int din_data_lsb(input int addr_w);
        return addr_w + 1;
    endfunction

endpackage

// File: rtl/mem_writer_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// mem_writer_arbiter_rr_pick
// Combinational two-way round-robin pick.
//   i_vld0, i_vld1 : request valids of client 0 / client 1
//   i_ptr          : client that wins when both request
//   o_any          : at least one client requests
//   o_idx          : index of the chosen client
// -----------------------------------------------------------------------------
module mem_writer_arbiter_rr_pick
    import mem_writer_arbiter_pkg::*;
(
    input  logic i_vld0,
    input  logic i_vld1,
    input  logic i_ptr,
    output logic o_any,
    output logic o_idx
);

    assign o_any = i_vld0 | i_vld1;
    // A lone requester always wins; the pointer only breaks ties.
    assign o_idx = (i_vld0 & i_vld1) ? i_ptr : i_vld1;

endmodule

// File: rtl/mem_writer_arbiter.sv
// -----------------------------------------------------------------------------
// mem_writer_arbiter
// Shares one MemWriter between two write clients, one transaction (request,
// data beats, response) at a time, with round-robin fairness on ties.
// Only the granted client's req/data_in/resp channels are forwarded
// (combinational pass-through); the other client sees rdy=0 and resp_vld=0.
//
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   reqN_data/vld/rdy           : client N write request {offset, length}
//   dataN_in_data/vld/rdy       : client N data beat {data, length, last}
//   respN_data/vld/rdy          : client N response status (0 = OKAY)
//   mw_req_*, mw_data_in_*      : towards MemWriter req_in / data_in
//   mw_resp_*                   : from MemWriter resp
//   grant                       : client currently owning the MemWriter
//   busy                        : FSM is not IDLE
// Optional build macro MEM_WRITER_ARBITER_STATS_EN adds:
//   grant_cnt0, grant_cnt1      : saturating completed-transaction counters
//   err_sticky                  : set once an error response is delivered
// -----------------------------------------------------------------------------
module mem_writer_arbiter
    import mem_writer_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,

    input  logic [2*ADDR_W-1:0]      req0_data,
    input  logic                     req0_vld,
    output logic                     req0_rdy,
    input  logic [2*ADDR_W-1:0]      req1_data,
    input  logic                     req1_vld,
    output logic                     req1_rdy,

    input  logic [DATA_W+ADDR_W:0]   data0_in_data,
    input  logic                     data0_in_vld,
    output logic                     data0_in_rdy,
    input  logic [DATA_W+ADDR_W:0]   data1_in_data,
    input  logic                     data1_in_vld,
    output logic                     data1_in_rdy,

    output logic                     resp0_data,
    output logic                     resp0_vld,
    input  logic                     resp0_rdy,
    output logic                     resp1_data,
    output logic                     resp1_vld,
    input  logic                     resp1_rdy,

    output logic [2*ADDR_W-1:0]      mw_req_data,
    output logic                     mw_req_vld,
    input  logic                     mw_req_rdy,
    output logic [DATA_W+ADDR_W:0]   mw_data_in_data,
    output logic                     mw_data_in_vld,
    input  logic                     mw_data_in_rdy,
    input  logic                     mw_resp_data,
    input  logic                     mw_resp_vld,
    output logic                     mw_resp_rdy,

    output logic                     grant,
    output logic                     busy
`ifdef MEM_WRITER_ARBITER_STATS_EN
    ,
    output logic [15:0]              grant_cnt0,
    output logic [15:0]              grant_cnt1,
    output logic                     err_sticky
`endif
);

    localparam int REQ_W = req_width(ADDR_W);
    localparam int DIN_W = data_in_width(ADDR_W, DATA_W);

    state_e r_state;
    logic   r_grant;
    logic   r_ptr;

    logic             w_any;
    logic             w_idx;
    logic [REQ_W-1:0] w_req_data;
    logic             w_req_vld;
    logic [DIN_W-1:0] w_din_data;
    logic             w_din_vld;
    logic             w_resp_rdy;
    logic             w_req_hs;
    logic             w_din_hs;
    logic             w_resp_hs;
    logic             w_req_len_zero;
    logic             w_din_last;

    mem_writer_arbiter_rr_pick u_pick (
        .i_vld0 (req0_vld),
        .i_vld1 (req1_vld),
        .i_ptr  (r_ptr),
        .o_any  (w_any),
        .o_idx  (w_idx)
    );

    // Granted client's channels, selected before state gating.
    assign w_req_data = r_grant ? req1_data     : req0_data;
    assign w_req_vld  = r_grant ? req1_vld      : req0_vld;
    assign w_din_data = r_grant ? data1_in_data : data0_in_data;
    assign w_din_vld  = r_grant ? data1_in_vld  : data0_in_vld;
    assign w_resp_rdy = r_grant ? resp1_rdy     : resp0_rdy;

    assign w_req_hs  = (r_state == REQ)  && mw_req_vld     && mw_req_rdy;
    assign w_din_hs  = (r_state == DATA) && mw_data_in_vld && mw_data_in_rdy;
    assign w_resp_hs = (r_state == RESP) && mw_resp_vld    && mw_resp_rdy;

    assign w_req_len_zero = (w_req_data[REQ_LEN_LSB +: ADDR_W] == '0);
    assign w_din_last     = w_din_data[DIN_LAST_BIT];

    assign grant = r_grant;
    assign busy  = (r_state != IDLE);

    // Pass-through for the phase currently active; everything else is held
    // at zero so idle channels never leak stale client data.
    always_comb begin
        req0_rdy        = 1'b0;
        req1_rdy        = 1'b0;
        data0_in_rdy    = 1'b0;
        data1_in_rdy    = 1'b0;
        resp0_data      = RESP_OKAY;
        resp0_vld       = 1'b0;
        resp1_data      = RESP_OKAY;
        resp1_vld       = 1'b0;
        mw_req_data     = '0;
        mw_req_vld      = 1'b0;
        mw_data_in_data = '0;
        mw_data_in_vld  = 1'b0;
        mw_resp_rdy     = 1'b0;
        case (r_state)
            REQ: begin
                mw_req_data = w_req_data;
                mw_req_vld  = w_req_vld;
                if (r_grant) req1_rdy = mw_req_rdy;
                else         req0_rdy = mw_req_rdy;
            end
            DATA: begin
                mw_data_in_data = w_din_data;
                mw_data_in_vld  = w_din_vld;
                if (r_grant) data1_in_rdy = mw_data_in_rdy;
                else         data0_in_rdy = mw_data_in_rdy;
            end
            RESP: begin
                mw_resp_rdy = w_resp_rdy;
                if (r_grant) begin
                    resp1_data = mw_resp_data;
                    resp1_vld  = mw_resp_vld;
                end else begin
                    resp0_data = mw_resp_data;
                    resp0_vld  = mw_resp_vld;
                end
            end
            default: ;
        endcase
    end

    // Transaction FSM. A reset mid-transaction simply drops the grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_grant <= 1'b0;
            r_ptr   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_grant <= w_idx;
                        r_state <= REQ;
                    end
                end
                REQ: begin
                    if (w_req_hs) r_state <= w_req_len_zero ? RESP : DATA;
                end
                DATA: begin
                    // Beat count is not tracked; the last flag alone ends the phase.
                    if (w_din_hs && w_din_last) r_state <= RESP;
                end
                RESP: begin
                    if (w_resp_hs) begin
                        r_ptr   <= ~r_grant;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef MEM_WRITER_ARBITER_STATS_EN
    logic [15:0] r_grant_cnt0;
    logic [15:0] r_grant_cnt1;
    logic        r_err_sticky;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant_cnt0 <= '0;
            r_grant_cnt1 <= '0;
            r_err_sticky <= 1'b0;
        end else if (w_resp_hs) begin
            if (r_grant) r_grant_cnt1 <= sat_inc16(r_grant_cnt1);
            else         r_grant_cnt0 <= sat_inc16(r_grant_cnt0);
            if (mw_resp_data == RESP_ERROR) r_err_sticky <= 1'b1;
        end
    end

    assign grant_cnt0 = r_grant_cnt0;
    assign grant_cnt1 = r_grant_cnt1;
    assign err_sticky = r_err_sticky;
`endif

endmodule

// File: tb/tb_mem_writer_arbiter.sv
module tb_mem_writer_arbiter;

    localparam int AW   = 16;
    localparam int DW   = 32;
    localparam int DINW = DW + AW + 1;

    logic            clk = 1'b0;
    logic            rst;
    logic [2*AW-1:0] req0_data, req1_data;
    logic            req0_vld, req1_vld, req0_rdy, req1_rdy;
    logic [DINW-1:0] data0_in_data, data1_in_data;
    logic            data0_in_vld, data1_in_vld, data0_in_rdy, data1_in_rdy;
    logic            resp0_data, resp0_vld, resp0_rdy;
    logic            resp1_data, resp1_vld, resp1_rdy;
    logic [2*AW-1:0] mw_req_data;
    logic            mw_req_vld, mw_req_rdy;
    logic [DINW-1:0] mw_data_in_data;
    logic            mw_data_in_vld, mw_data_in_rdy;
    logic            mw_resp_data, mw_resp_vld, mw_resp_rdy;
    logic            grant, busy;
`ifdef MEM_WRITER_ARBITER_STATS_EN
    logic [15:0]     grant_cnt0, grant_cnt1;
    logic            err_sticky;
`endif

    always #5 clk = ~clk;

    mem_writer_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk             (clk),
        .rst             (rst),
        .req0_data       (req0_data),
        .req0_vld        (req0_vld),
        .req0_rdy        (req0_rdy),
        .req1_data       (req1_data),
        .req1_vld        (req1_vld),
        .req1_rdy        (req1_rdy),
        .data0_in_data   (data0_in_data),
        .data0_in_vld    (data0_in_vld),
        .data0_in_rdy    (data0_in_rdy),
        .data1_in_data   (data1_in_data),
        .data1_in_vld    (data1_in_vld),
        .data1_in_rdy    (data1_in_rdy),
        .resp0_data      (resp0_data),
        .resp0_vld       (resp0_vld),
        .resp0_rdy       (resp0_rdy),
        .resp1_data      (resp1_data),
        .resp1_vld       (resp1_vld),
        .resp1_rdy       (resp1_rdy),
        .mw_req_data     (mw_req_data),
        .mw_req_vld      (mw_req_vld),
        .mw_req_rdy      (mw_req_rdy),
        .mw_data_in_data (mw_data_in_data),
        .mw_data_in_vld  (mw_data_in_vld),
        .mw_data_in_rdy  (mw_data_in_rdy),
        .mw_resp_data    (mw_resp_data),
        .mw_resp_vld     (mw_resp_vld),
        .mw_resp_rdy     (mw_resp_rdy),
        .grant           (grant),
        .busy            (busy)
`ifdef MEM_WRITER_ARBITER_STATS_EN
        ,
        .grant_cnt0      (grant_cnt0),
        .grant_cnt1      (grant_cnt1),
        .err_sticky      (err_sticky)
`endif
    );

    // Input control bits of a vector row
    localparam logic [10:0] I_RST   = 11'h400;
    localparam logic [10:0] I_Q0V   = 11'h200;
    localparam logic [10:0] I_Q1V   = 11'h100;
    localparam logic [10:0] I_D0V   = 11'h080;
    localparam logic [10:0] I_D1V   = 11'h040;
    localparam logic [10:0] I_R0RDY = 11'h020;
    localparam logic [10:0] I_R1RDY = 11'h010;
    localparam logic [10:0] I_MQRDY = 11'h008;
    localparam logic [10:0] I_MDRDY = 11'h004;
    localparam logic [10:0] I_MRV   = 11'h002;
    localparam logic [10:0] I_MRD   = 11'h001;

    // Expected control outputs of a vector row
    localparam logic [12:0] O_Q0RDY  = 13'h1000;
    localparam logic [12:0] O_Q1RDY  = 13'h0800;
    localparam logic [12:0] O_D0RDY  = 13'h0400;
    localparam logic [12:0] O_D1RDY  = 13'h0200;
    localparam logic [12:0] O_R0V    = 13'h0100;
    localparam logic [12:0] O_R0D    = 13'h0080;
    localparam logic [12:0] O_R1V    = 13'h0040;
    localparam logic [12:0] O_R1D    = 13'h0020;
    localparam logic [12:0] O_MQV    = 13'h0010;
    localparam logic [12:0] O_MDV    = 13'h0008;
    localparam logic [12:0] O_MRRDY  = 13'h0004;
    localparam logic [12:0] O_GNT    = 13'h0002;
    localparam logic [12:0] O_BUSY   = 13'h0001;

    localparam logic [31:0]   REQ_A = 32'h0010_0008;
    localparam logic [31:0]   REQ_T0 = 32'h1234_0000;
    localparam logic [31:0]   REQ_T1 = 32'h5678_0000;
    localparam logic [DINW-1:0] DA0 = {32'hAAAA_0001, 16'd4, 1'b0};
    localparam logic [DINW-1:0] DA1 = {32'hBBBB_0002, 16'd4, 1'b1};
    localparam logic [DINW-1:0] DX  = {32'hDEAD_BEEF, 16'd4, 1'b1};

    typedef struct {
        string           nm;
        logic [10:0]     in;
        logic [31:0]     q0d;
        logic [31:0]     q1d;
        logic [DINW-1:0] d0d;
        logic [DINW-1:0] d1d;
        logic [12:0]     ex;
        logic [31:0]     ex_mreq;
        logic [DINW-1:0] ex_mdin;
    } vec_t;

    vec_t tbl[$];
    int   n_checks = 0;
    int   n_err    = 0;

    logic [DINW-1:0] bp_beats [3];
    logic [63:0]     got[$];
    logic [0:3]      pat;
    int              k;
    int              ncyc;
    logic            rdy_now;

    function automatic vec_t mk(input string nm, input logic [10:0] in,
                                input logic [31:0] q0d, input logic [31:0] q1d,
                                input logic [DINW-1:0] d0d, input logic [DINW-1:0] d1d,
                                input logic [12:0] ex, input logic [31:0] ex_mreq,
                                input logic [DINW-1:0] ex_mdin);
        vec_t v;
        v.nm = nm; v.in = in; v.q0d = q0d; v.q1d = q1d; v.d0d = d0d; v.d1d = d1d;
        v.ex = ex; v.ex_mreq = ex_mreq; v.ex_mdin = ex_mdin;
        return v;
    endfunction

    function automatic logic [12:0] outs();
        return {req0_rdy, req1_rdy, data0_in_rdy, data1_in_rdy,
                resp0_vld, resp0_data, resp1_vld, resp1_data,
                mw_req_vld, mw_data_in_vld, mw_resp_rdy, grant, busy};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        rst = 1'b0;
        req0_vld = 1'b0; req1_vld = 1'b0; req0_data = '0; req1_data = '0;
        data0_in_vld = 1'b0; data1_in_vld = 1'b0; data0_in_data = '0; data1_in_data = '0;
        resp0_rdy = 1'b0; resp1_rdy = 1'b0;
        mw_req_rdy = 1'b0; mw_data_in_rdy = 1'b0; mw_resp_vld = 1'b0; mw_resp_data = 1'b0;
    endtask

    task automatic apply(input vec_t v);
        rst            = v.in[10];
        req0_vld       = v.in[9];
        req1_vld       = v.in[8];
        data0_in_vld   = v.in[7];
        data1_in_vld   = v.in[6];
        resp0_rdy      = v.in[5];
        resp1_rdy      = v.in[4];
        mw_req_rdy     = v.in[3];
        mw_data_in_rdy = v.in[2];
        mw_resp_vld    = v.in[1];
        mw_resp_data   = v.in[0];
        req0_data      = v.q0d;
        req1_data      = v.q1d;
        data0_in_data  = v.d0d;
        data1_in_data  = v.d1d;
    endtask

    // Zero-length transaction for client c; the response status is err.
    task automatic run_zero(input int c, input logic err);
        bit done = 1'b0;
        bit hs_req, hs_resp;
        @(negedge clk);
        idle_inputs();
        mw_req_rdy = 1'b1; mw_resp_vld = 1'b1; mw_resp_data = err;
        if (c == 0) begin req0_vld = 1'b1; req0_data = 32'h0050_0000; resp0_rdy = 1'b1; end
        else        begin req1_vld = 1'b1; req1_data = 32'h0060_0000; resp1_rdy = 1'b1; end
        for (int i = 0; i < 8 && !done; i++) begin
            #1;
            hs_req  = (c == 0) ? (req0_vld && req0_rdy) : (req1_vld && req1_rdy);
            hs_resp = (c == 0) ? resp0_vld : resp1_vld;
            @(negedge clk);
            if (hs_req) begin req0_vld = 1'b0; req1_vld = 1'b0; end
            if (hs_resp) done = 1'b1;
        end
        chk($sformatf("xact_done_c%0d", c), {63'd0, done}, 64'd1);
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);

        // Single client, two beats; client 1 stray data must never see rdy
        tbl.push_back(mk("rst_state", 11'h0, 0, 0, 0, 0, 13'h0, 0, 0));
        tbl.push_back(mk("s1_idle", I_Q0V|I_R0RDY|I_MQRDY|I_MDRDY, REQ_A, 0, 0, 0, 13'h0, 0, 0));
        tbl.push_back(mk("s1_req", I_Q0V|I_R0RDY|I_MQRDY|I_MDRDY, REQ_A, 0, 0, 0,
                         O_Q0RDY|O_MQV|O_BUSY, REQ_A, 0));
        tbl.push_back(mk("s1_beat0", I_D0V|I_D1V|I_R0RDY|I_MQRDY|I_MDRDY, 0, 0, DA0, DX,
                         O_D0RDY|O_MDV|O_BUSY, 0, DA0));
        tbl.push_back(mk("s1_beat1", I_D0V|I_D1V|I_R0RDY|I_MQRDY|I_MDRDY, 0, 0, DA1, DX,
                         O_D0RDY|O_MDV|O_BUSY, 0, DA1));
        tbl.push_back(mk("s1_resp", I_MRV|I_R0RDY|I_MQRDY|I_MDRDY, 0, 0, 0, 0,
                         O_R0V|O_MRRDY|O_BUSY, 0, 0));
        tbl.push_back(mk("s1_done", I_R0RDY, 0, 0, 0, 0, 13'h0, 0, 0));
        tbl.push_back(mk("rst_row", I_RST, 0, 0, 0, 0, 13'h0, 0, 0));
        // Tie after reset: client 0 first, then client 1
        tbl.push_back(mk("tie1_idle", I_Q0V|I_Q1V|I_MQRDY|I_MRV|I_R0RDY|I_R1RDY, REQ_T0, REQ_T1, 0, 0,
                         13'h0, 0, 0));
        tbl.push_back(mk("tie1_req0", I_Q0V|I_Q1V|I_MQRDY|I_MRV|I_R0RDY|I_R1RDY, REQ_T0, REQ_T1, 0, 0,
                         O_Q0RDY|O_MQV|O_BUSY, REQ_T0, 0));
        tbl.push_back(mk("tie1_resp0", I_Q1V|I_MQRDY|I_MRV|I_R0RDY|I_R1RDY, REQ_T0, REQ_T1, 0, 0,
                         O_R0V|O_MRRDY|O_BUSY, 0, 0));
        tbl.push_back(mk("tie1_idle1", I_Q1V|I_MQRDY|I_MRV|I_R0RDY|I_R1RDY, REQ_T0, REQ_T1, 0, 0,
                         13'h0, 0, 0));
        tbl.push_back(mk("tie1_req1", I_Q1V|I_MQRDY|I_MRV|I_R0RDY|I_R1RDY, REQ_T0, REQ_T1, 0, 0,
                         O_Q1RDY|O_MQV|O_GNT|O_BUSY, REQ_T1, 0));
        tbl.push_back(mk("tie1_resp1", I_MQRDY|I_MRV|I_R0RDY|I_R1RDY, REQ_T0, REQ_T1, 0, 0,
                         O_R1V|O_MRRDY|O_GNT|O_BUSY, 0, 0));
        // Second tie: pointer is back on client 0
        tbl.push_back(mk("tie2_idle", I_Q0V|I_Q1V|I_MQRDY|I_MRV|I_R0RDY|I_R1RDY, REQ_T0, REQ_T1, 0, 0,
                         O_GNT, 0, 0));
        tbl.push_back(mk("tie2_req0", I_Q0V|I_Q1V|I_MQRDY|I_MRV|I_R0RDY|I_R1RDY, REQ_T0, REQ_T1, 0, 0,
                         O_Q0RDY|O_MQV|O_BUSY, REQ_T0, 0));
        tbl.push_back(mk("tie2_resp0", I_Q1V|I_D1V|I_MQRDY|I_MRV|I_R0RDY|I_R1RDY, REQ_T0, REQ_T1, 0, DX,
                         O_R0V|O_MRRDY|O_BUSY, 0, 0));
        // Zero-length client 1 request with error status: no data phase
        tbl.push_back(mk("zl_idle", I_Q1V|I_D1V|I_MQRDY|I_MRV|I_R0RDY|I_R1RDY, 0, REQ_T1, 0, DX,
                         13'h0, 0, 0));
        tbl.push_back(mk("zl_req1", I_Q1V|I_D1V|I_MQRDY|I_MRV|I_R0RDY|I_R1RDY, 0, REQ_T1, 0, DX,
                         O_Q1RDY|O_MQV|O_GNT|O_BUSY, REQ_T1, 0));
        tbl.push_back(mk("zl_resp1", I_D1V|I_MQRDY|I_MRV|I_MRD|I_R0RDY|I_R1RDY, 0, REQ_T1, 0, DX,
                         O_R1V|O_R1D|O_MRRDY|O_GNT|O_BUSY, 0, 0));
        tbl.push_back(mk("zl_done", 11'h0, 0, 0, 0, 0, O_GNT, 0, 0));

        foreach (tbl[i]) begin
            @(negedge clk);
            apply(tbl[i]);
            #1;
            chk({tbl[i].nm, "_ctl"},  {51'd0, outs()},          {51'd0, tbl[i].ex});
            chk({tbl[i].nm, "_mreq"}, {32'd0, mw_req_data},      {32'd0, tbl[i].ex_mreq});
            chk({tbl[i].nm, "_mdin"}, {15'd0, mw_data_in_data},  {15'd0, tbl[i].ex_mdin});
        end

        // Backpressure on client 1: data rdy 1,0,0,1 then resp held off 5 cycles
        bp_beats[0] = {32'h1111_0000, 16'd12, 1'b0};
        bp_beats[1] = {32'h2222_0000, 16'd12, 1'b0};
        bp_beats[2] = {32'h3333_0000, 16'd12, 1'b1};
        pat = 4'b1001;
        @(negedge clk);
        idle_inputs();
        req1_vld = 1'b1; req1_data = 32'h0020_000C; mw_req_rdy = 1'b1;
        #1 chk("bp_idle_busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        #1 chk("bp_req_rdy", {63'd0, req1_rdy}, 64'd1);
        chk("bp_grant", {63'd0, grant}, 64'd1);
        @(negedge clk);
        req1_vld = 1'b0; data1_in_vld = 1'b1; k = 0; ncyc = 0; got.delete();
        for (int i = 0; i < 12 && k < 3; i++) begin
            rdy_now = (i < 4) ? pat[i] : 1'b1;
            data1_in_data = bp_beats[k];
            mw_data_in_rdy = rdy_now;
            #1;
            chk($sformatf("bp_vld_%0d", i), {63'd0, mw_data_in_vld}, 64'd1);
            chk($sformatf("bp_data_%0d", i), {15'd0, mw_data_in_data}, {15'd0, bp_beats[k]});
            chk($sformatf("bp_rdy_%0d", i), {63'd0, data1_in_rdy}, {63'd0, rdy_now});
            if (mw_data_in_vld && mw_data_in_rdy) begin
                got.push_back({15'd0, mw_data_in_data});
                k++;
            end
            ncyc++;
            @(negedge clk);
        end
        chk("bp_beat_count", 64'(k), 64'd3);
        chk("bp_cycles", 64'(ncyc), 64'd5);
        foreach (got[j]) chk($sformatf("bp_got_%0d", j), got[j], {15'd0, bp_beats[j]});
        data1_in_vld = 1'b0; mw_data_in_rdy = 1'b0;
        mw_resp_vld = 1'b1; mw_resp_data = 1'b0; resp1_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("bp_hold_vld_%0d", i), {63'd0, resp1_vld}, 64'd1);
            chk($sformatf("bp_hold_rdy_%0d", i), {63'd0, mw_resp_rdy}, 64'd0);
            chk($sformatf("bp_hold_busy_%0d", i), {63'd0, busy}, 64'd1);
            @(negedge clk);
        end
        resp1_rdy = 1'b1;
        #1 chk("bp_resp_rdy", {63'd0, mw_resp_rdy}, 64'd1);
        @(negedge clk);
        idle_inputs();
        #1 chk("bp_done_busy", {63'd0, busy}, 64'd0);
        chk("bp_done_vld", {63'd0, resp1_vld}, 64'd0);

        // Reset in the middle of a 3-beat client 0 transfer
        @(negedge clk);
        req0_vld = 1'b1; req0_data = 32'h0030_000C; mw_req_rdy = 1'b1; mw_data_in_rdy = 1'b1;
        @(negedge clk);
        #1 chk("rm_req_rdy", {63'd0, req0_rdy}, 64'd1);
        @(negedge clk);
        req0_vld = 1'b0; data0_in_vld = 1'b1; data0_in_data = {32'h4444_0000, 16'd12, 1'b0};
        #1 chk("rm_beat0_rdy", {63'd0, data0_in_rdy}, 64'd1);
        @(negedge clk);
        data0_in_data = {32'h5555_0000, 16'd12, 1'b0}; rst = 1'b1;
        #1 chk("rm_pre_busy", {63'd0, busy}, 64'd1);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("rm_ctl_zero", {51'd0, outs()}, 64'd0);
        chk("rm_mreq_zero", {32'd0, mw_req_data}, 64'd0);
        chk("rm_mdin_zero", {15'd0, mw_data_in_data}, 64'd0);
        data0_in_vld = 1'b0; req1_vld = 1'b1; req1_data = 32'h0040_0000;
        @(negedge clk);
        #1 chk("rm_new_grant", {63'd0, grant}, 64'd1);
        chk("rm_new_rdy", {63'd0, req1_rdy}, 64'd1);
        chk("rm_new_mreq", {32'd0, mw_req_data}, 64'h0040_0000);
        @(negedge clk);
        req1_vld = 1'b0; mw_resp_vld = 1'b1; resp1_rdy = 1'b1;
        #1 chk("rm_new_resp", {63'd0, resp1_vld}, 64'd1);
        @(negedge clk);
        idle_inputs();
        #1 chk("rm_new_idle", {63'd0, busy}, 64'd0);

`ifdef MEM_WRITER_ARBITER_STATS_EN
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1 chk("st_cnt0_rst", {48'd0, grant_cnt0}, 64'd0);
        chk("st_err_rst", {63'd0, err_sticky}, 64'd0);
        run_zero(0, 1'b0);
        run_zero(1, 1'b0);
        run_zero(0, 1'b1);
        run_zero(1, 1'b0);
        run_zero(0, 1'b0);
        #1 chk("st_cnt0", {48'd0, grant_cnt0}, 64'd3);
        chk("st_cnt1", {48'd0, grant_cnt1}, 64'd2);
        chk("st_err", {63'd0, err_sticky}, 64'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
